// File: rtl/cpu_clk_en_gen.sv
// CPU clock-enable generator: synchronises the step button and mode switches,
// debounces the button and emits a one-cycle cpu_ce per CPU step.
module cpu_clk_en_gen #(
  parameter int unsigned DIV_SLOW   = 6000000,
  parameter int unsigned DIV_FAST   = 600000,
  parameter int unsigned DEB_CYCLES = 120000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        clk_btn,
  input  logic [1:0]  clk_sel,
  output logic        cpu_ce,
  output logic [1:0]  mode,
  output logic [15:0] ce_count
);

  localparam int unsigned DEB_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [23:0]      SLOW_LAST = 24'(DIV_SLOW - 1);
  localparam logic [23:0]      FAST_LAST = 24'(DIV_FAST - 1);

  typedef enum logic [1:0] {
    MODE_STEP = 2'b00,
    MODE_SLOW = 2'b01,
    MODE_FAST = 2'b10,
    MODE_FULL = 2'b11
  } mode_e;

  logic             btn_s1_q, btn_s1_d;
  logic             btn_s2_q, btn_s2_d;
  logic [1:0]       sel_s1_q, sel_s1_d;
  logic [1:0]       sel_s2_q, sel_s2_d;
  logic             deb_q, deb_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             deb_prev_q, deb_prev_d;
  logic             step_req_q, step_req_d;
  mode_e            mode_q, mode_d;
  logic [23:0]      div_q, div_d;
  logic             tick;
  logic             cpu_ce_q, cpu_ce_d;
  logic [15:0]      ce_count_q, ce_count_d;

  always_comb begin
    btn_s1_d = clk_btn;
    btn_s2_d = btn_s1_q;
    sel_s1_d = clk_sel;
    sel_s2_d = sel_s1_q;

    // Any cycle where the synchronised level agrees with the debounced one restarts the hold window.
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (btn_s2_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d = btn_s2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end

    deb_prev_d = deb_q;
    step_req_d = deb_prev_q & ~deb_q;

    mode_d   = mode_q;
    div_d    = '0;
    tick     = 1'b0;
    cpu_ce_d = 1'b0;
    unique case (mode_q)
      MODE_STEP: cpu_ce_d = step_req_q;
      MODE_SLOW: begin
        tick     = (div_q == SLOW_LAST);
        div_d    = tick ? '0 : div_q + 24'd1;
        cpu_ce_d = tick;
      end
      MODE_FAST: begin
        tick     = (div_q == FAST_LAST);
        div_d    = tick ? '0 : div_q + 24'd1;
        cpu_ce_d = tick;
      end
      MODE_FULL: cpu_ce_d = 1'b1;
      default:   cpu_ce_d = 1'b0;
    endcase

    // A mode change suppresses this cycle's enable, so a coincident step or tick is dropped.
    if (mode_e'(sel_s2_q) != mode_q) begin
      mode_d   = mode_e'(sel_s2_q);
      div_d    = '0;
      cpu_ce_d = 1'b0;
    end

    ce_count_d = ce_count_q + 16'(cpu_ce_q);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      btn_s1_q   <= 1'b1;
      btn_s2_q   <= 1'b1;
      sel_s1_q   <= '0;
      sel_s2_q   <= '0;
      deb_q      <= 1'b1;
      deb_cnt_q  <= '0;
      deb_prev_q <= 1'b1;
      step_req_q <= 1'b0;
      mode_q     <= MODE_STEP;
      div_q      <= '0;
      cpu_ce_q   <= 1'b0;
      ce_count_q <= '0;
    end else begin
      btn_s1_q   <= btn_s1_d;
      btn_s2_q   <= btn_s2_d;
      sel_s1_q   <= sel_s1_d;
      sel_s2_q   <= sel_s2_d;
      deb_q      <= deb_d;
      deb_cnt_q  <= deb_cnt_d;
      deb_prev_q <= deb_prev_d;
      step_req_q <= step_req_d;
      mode_q     <= mode_d;
      div_q      <= div_d;
      cpu_ce_q   <= cpu_ce_d;
      ce_count_q <= ce_count_d;
    end
  end

  assign cpu_ce   = cpu_ce_q;
  assign mode     = mode_q;
  assign ce_count = ce_count_q;

endmodule

// File: tb/tb_cpu_clk_en_gen.sv
// Directed bench for cpu_clk_en_gen with small divider/debounce parameters.
module tb_cpu_clk_en_gen;

  logic        clk;
  logic        nrst;
  logic        clk_btn;
  logic [1:0]  clk_sel;
  logic        cpu_ce;
  logic [1:0]  mode;
  logic [15:0] ce_count;

  int unsigned n_pass;
  int unsigned n_total;
  int unsigned pulses;

  cpu_clk_en_gen #(
    .DIV_SLOW  (10),
    .DIV_FAST  (4),
    .DEB_CYCLES(8)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .clk_btn (clk_btn),
    .clk_sel (clk_sel),
    .cpu_ce  (cpu_ce),
    .mode    (mode),
    .ce_count(ce_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        nrst;
    logic        btn;
    logic [1:0]  sel;
    int unsigned cycles;
    logic        ce;
    logic [1:0]  md;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, got, exp);
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (cpu_ce === 1'b1) pulses++;
    end
  endtask

  initial begin
    int unsigned p0;
    int unsigned bad;
    logic        saw_zero;

    n_pass  = 0;
    n_total = 0;
    pulses  = 0;
    nrst    = 1'b0;
    clk_btn = 1'b1;
    clk_sel = 2'b00;

    //              nrst  btn   sel    cyc  ce    mode   count
    vecs[0]  = '{1'b0, 1'b1, 2'b00, 3,  1'b0, 2'b00, 16'd0};
    vecs[1]  = '{1'b1, 1'b1, 2'b00, 5,  1'b0, 2'b00, 16'd0};
    vecs[2]  = '{1'b1, 1'b0, 2'b00, 11, 1'b0, 2'b00, 16'd0};
    vecs[3]  = '{1'b1, 1'b0, 2'b00, 1,  1'b1, 2'b00, 16'd0};
    vecs[4]  = '{1'b1, 1'b0, 2'b00, 1,  1'b0, 2'b00, 16'd1};
    vecs[5]  = '{1'b1, 1'b0, 2'b00, 37, 1'b0, 2'b00, 16'd1};
    vecs[6]  = '{1'b1, 1'b1, 2'b00, 20, 1'b0, 2'b00, 16'd1};
    vecs[7]  = '{1'b1, 1'b0, 2'b00, 12, 1'b1, 2'b00, 16'd1};
    vecs[8]  = '{1'b1, 1'b1, 2'b00, 1,  1'b0, 2'b00, 16'd2};
    vecs[9]  = '{1'b1, 1'b1, 2'b00, 15, 1'b0, 2'b00, 16'd2};
    vecs[10] = '{1'b1, 1'b1, 2'b01, 2,  1'b0, 2'b00, 16'd2};
    vecs[11] = '{1'b1, 1'b1, 2'b01, 1,  1'b0, 2'b01, 16'd2};
    vecs[12] = '{1'b1, 1'b1, 2'b01, 9,  1'b0, 2'b01, 16'd2};
    vecs[13] = '{1'b1, 1'b1, 2'b01, 1,  1'b1, 2'b01, 16'd2};
    vecs[14] = '{1'b1, 1'b1, 2'b01, 10, 1'b1, 2'b01, 16'd3};
    vecs[15] = '{1'b1, 1'b0, 2'b01, 1,  1'b0, 2'b01, 16'd4};
    vecs[16] = '{1'b1, 1'b0, 2'b01, 9,  1'b1, 2'b01, 16'd4};
    vecs[17] = '{1'b1, 1'b1, 2'b01, 10, 1'b1, 2'b01, 16'd5};
    vecs[18] = '{1'b1, 1'b1, 2'b01, 5,  1'b0, 2'b01, 16'd6};

    for (int i = 0; i < 19; i++) begin
      nrst    = vecs[i].nrst;
      clk_btn = vecs[i].btn;
      clk_sel = vecs[i].sel;
      tick(vecs[i].cycles);
      check($sformatf("v%0d_ce", i), 32'(cpu_ce), 32'(vecs[i].ce));
      check($sformatf("v%0d_mode", i), 32'(mode), 32'(vecs[i].md));
      check($sformatf("v%0d_cnt", i), 32'(ce_count), 32'(vecs[i].cnt));
    end

    // Slow -> fast switch with the divider at 7: no pulse in the switch cycle, then every 4.
    clk_sel = 2'b10;
    tick(2);
    check("sw_pre_mode", 32'(mode), 32'd1);
    check("sw_pre_ce", 32'(cpu_ce), 32'd0);
    tick(1);
    check("sw_mode", 32'(mode), 32'd2);
    check("sw_ce", 32'(cpu_ce), 32'd0);
    p0 = pulses;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check($sformatf("sw_k%0d_ce", k), 32'(cpu_ce), (k == 4 || k == 8) ? 32'd1 : 32'd0);
    end
    check("sw_pulses", pulses - p0, 32'd2);
    check("sw_cnt", 32'(ce_count), 32'd7);

    // Reset mid-count in slow mode with the button held low.
    clk_sel = 2'b01;
    tick(3);
    check("rst_pre_mode", 32'(mode), 32'd1);
    tick(5);
    clk_btn = 1'b0;
    tick(3);
    #2;
    nrst    = 1'b0;
    clk_sel = 2'b00;
    #1;
    check("rst_async_ce", 32'(cpu_ce), 32'd0);
    check("rst_async_mode", 32'(mode), 32'd0);
    check("rst_async_cnt", 32'(ce_count), 32'd0);
    tick(2);
    nrst = 1'b1;
    p0   = pulses;
    tick(11);
    check("rst_no_early_pulse", pulses - p0, 32'd0);
    check("rst_rel_mode", 32'(mode), 32'd0);
    tick(1);
    check("rst_press_ce", 32'(cpu_ce), 32'd1);
    tick(1);
    check("rst_press_ce_end", 32'(cpu_ce), 32'd0);
    check("rst_press_cnt", 32'(ce_count), 32'd1);

    // Bouncing button: toggles every 3 cycles, never held long enough.
    clk_btn = 1'b1;
    tick(15);
    p0 = pulses;
    for (int i = 0; i < 40; i++) begin
      clk_btn = (((i / 3) % 2) == 0) ? 1'b0 : 1'b1;
      tick(1);
    end
    clk_btn = 1'b1;
    tick(20);
    check("bounce_pulses", pulses - p0, 32'd0);
    check("bounce_cnt", 32'(ce_count), 32'd1);

    // Full speed long enough for ce_count to wrap; button activity must have no effect.
    clk_sel = 2'b11;
    tick(2);
    check("full_pre_mode", 32'(mode), 32'd0);
    tick(1);
    check("full_mode", 32'(mode), 32'd3);
    check("full_entry_ce", 32'(cpu_ce), 32'd0);
    check("full_entry_cnt", 32'(ce_count), 32'd1);
    bad      = 0;
    saw_zero = 1'b0;
    for (int i = 0; i < 65540; i++) begin
      if (i == 100) clk_btn = 1'b0;
      if (i == 300) clk_btn = 1'b1;
      tick(1);
      if (cpu_ce !== 1'b1) bad++;
      if (ce_count == 16'h0000) saw_zero = 1'b1;
    end
    check("full_ce_low_cycles", bad, 32'd0);
    check("full_wrapped", 32'(saw_zero), 32'd1);
    check("full_final_cnt", 32'(ce_count), 32'd4);
    check("full_final_mode", 32'(mode), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
